debouncer: RTL and testbench
============================

Name: debouncer

Overview:
- Input-conditioning stage directly upstream of edge_detector. Takes raw asynchronous level inputs (buttons, switches, external strobes) and produces clean, clk-synchronous levels for edge_detector to convert into one-cycle pulses.
- Per bit: a multi-flop synchronizer, then a saturating sample counter driven by a shared sample tick.

Parameters:
- WIDTH, 1: number of independent input bits.
- SYNC_STAGES, 2: synchronizer flop depth; minimum 2.
- SAMPLE_CNT_MAX, 25000: clk cycles per sample tick; minimum 1.
- PULSE_CNT_MAX, 150: consecutive high samples required to assert the output; minimum 1.

Ports:
- clk  in  1  system clock; all state is posedge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- signal_in  in  WIDTH  raw asynchronous inputs.
- debounced_signal  out  WIDTH  debounced, clk-synchronous levels; feeds edge_detector.signal_in.
- sample_tick  out  1  one-cycle strobe marking sample instants; for observability and test.

Behaviour:
- Reset (async, active-high): synchronizer flops = 0, sample timer = 0, all per-bit counters = 0. debounced_signal = 0 and sample_tick = 0 while rst is high and immediately on assertion.
- Synchronizer: signal_in[i] passes through SYNC_STAGES flops. sync[i] is the last stage. Latency = SYNC_STAGES posedges. No logic between stages.
- Sample timer:
  - Free-running. Width = max(1, $clog2(SAMPLE_CNT_MAX)).
  - Increments every cycle and wraps to 0 when equal to SAMPLE_CNT_MAX-1.
  - sample_tick = (timer == SAMPLE_CNT_MAX-1), decoded combinationally from the timer register. This gives exactly one high cycle per SAMPLE_CNT_MAX cycles.
  - SAMPLE_CNT_MAX = 1 gives sample_tick high every cycle out of reset.
  - First tick is in the cycle after the (SAMPLE_CNT_MAX-1)th posedge following reset release.
- Per-bit counter cnt[i], width $clog2(PULSE_CNT_MAX+1), updated at each posedge in this priority order:
  - sync[i]==0: cnt <= 0 on every cycle, regardless of tick. Any low sample restarts qualification.
  - sync[i]==1 and sample_tick and cnt < PULSE_CNT_MAX: cnt <= cnt+1.
  - Otherwise: hold. Saturates at PULSE_CNT_MAX and never wraps.
- debounced_signal[i] = (cnt[i] == PULSE_CNT_MAX), compared directly off the register with no extra flop.
- Rise latency: SYNC_STAGES cycles, plus PULSE_CNT_MAX ticks while sync stays high. Total is between (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1 and PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles after sync rises, depending on timer phase.
- Fall latency: fixed SYNC_STAGES+1 posedges after signal_in falls (input changed between edges).
- Bits are fully independent; only the timer is shared.
- Simultaneous sync fall and tick: clear wins.
- Reset mid-qualification: counters clear, and after release qualification restarts from 0 with timer phase 0.
- Output can only change on posedge clk or async rst, so it is glitch-free into edge_detector.

Decomposition:
- No package typedefs needed. Counter widths are derived locally with $clog2.
- Minimum-value parameter checks are done at elaboration (generate-time $error).
- One natural sub-module: synchronizer (parameters WIDTH, SYNC_STAGES; ports clk, rst, d, q). It is reusable for other async inputs.
- Timer and per-bit counters stay in debouncer.

Test Plan:
- All tests use WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, 10 ns clk, and a 1000-cycle timeout that reports failure.
- Reset: assert rst mid-cycle with bit0 qualified high.
  - Required: debounced_signal=2'b00 and sample_tick=0 before the next posedge.
  - Required: after release, sample_tick first high after 3 posedges, then every 4 cycles.
- Steady press: bit0=1 held 40 cycles.
  - Required: debounced_signal[0] rises within 12 cycles after sync rises, stays 1, and does not wrap.
  - Required: bit1 stays 0.
- Bounce rejection: bit0 toggles every 3 cycles for 60 cycles.
  - Required: debounced_signal[0] never asserts, since cnt clears on every low sync.
- Release: after qualified high, set bit0=0 1 ns after a posedge.
  - Required: debounced_signal[0] low exactly after the 3rd subsequent posedge.
- Independence and simultaneous events: bit0 steady high, bit1 drops in the same cycle as a tick.
  - Required: bit1 cnt cleared (clear beats increment).
  - Required: bit0 qualifies with unchanged latency.
- Chain check: debouncer output drives edge_detector (WIDTH=2).
  - Required: a 40-cycle press yields exactly one 1-cycle edge_detect_pulse[0].
  - Required: a bouncy press yields zero pulses.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared sizing helpers for the debouncer and its synchronizer.
package debouncer_pkg;

  // Width of the free-running sample timer. It is never narrower than one bit,
  // so a single-cycle sample period still has a register to decode.
  function automatic int timer_width(input int sample_cnt_max);
    int w;
    w = $clog2(sample_cnt_max);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of a per-bit qualification counter. It must hold PULSE_CNT_MAX itself.
  function automatic int count_width(input int pulse_cnt_max);
    return $clog2(pulse_cnt_max + 1);
  endfunction

  // Smallest synchronizer depth that gives metastability a full cycle to settle.
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/debouncer_synchronizer.sv
// Multi-flop synchronizer for asynchronous level inputs. Each bit passes
// through SYNC_STAGES back-to-back flops with no logic between stages.
module debouncer_synchronizer
  import debouncer_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("debouncer_synchronizer: SYNC_STAGES must be at least 2");
  end

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  // Shift the raw input through the flop chain; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage[s] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage[s] <= stage[s-1];
      end
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronizes raw asynchronous levels and only asserts an output
// bit after PULSE_CNT_MAX consecutive high samples, taken once every
// SAMPLE_CNT_MAX clocks. Any low synchronized value restarts qualification.
// The outputs come straight off registers so they are glitch-free for the
// edge detector that follows.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal_in,
  output logic [WIDTH-1:0] debounced_signal,
  output logic             sample_tick
);

  localparam int TW = timer_width(SAMPLE_CNT_MAX);
  localparam int CW = count_width(PULSE_CNT_MAX);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(PULSE_CNT_MAX);

  if (WIDTH < 1) begin : g_bad_width
    $error("debouncer: WIDTH must be at least 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("debouncer: SYNC_STAGES must be at least 2");
  end
  if (SAMPLE_CNT_MAX < 1) begin : g_bad_sample
    $error("debouncer: SAMPLE_CNT_MAX must be at least 1");
  end
  if (PULSE_CNT_MAX < 1) begin : g_bad_pulse
    $error("debouncer: PULSE_CNT_MAX must be at least 1");
  end

  logic [WIDTH-1:0] sync;
  logic [TW-1:0]    timer;
  logic             tick_raw;

  debouncer_synchronizer #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (signal_in),
    .q   (sync)
  );

  // Free-running sample timer shared by all bits; wraps at SAMPLE_CNT_MAX-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // The tick is decoded from the timer register. With a one-cycle period the
  // timer sits at its last value even in reset, so rst masks the strobe.
  assign tick_raw    = (timer == TIMER_LAST);
  assign sample_tick = tick_raw & ~rst;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [CW-1:0] cnt;

    // Qualification counter: a low sample clears (beating any tick), a high
    // sample on a tick counts up, and the count saturates at PULSE_CNT_MAX.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (!sync[g]) begin
        cnt <= '0;
      end else if (tick_raw && (cnt < CNT_FULL)) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign debounced_signal[g] = (cnt == CNT_FULL);
  end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer with WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4,
// PULSE_CNT_MAX=3 and a 10 ns clock.
module tb_debouncer;

  localparam int SMAX    = 4;
  localparam int PMAX    = 3;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] signal_in = 2'b00;
  logic [1:0] debounced_signal;
  logic       sample_tick;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard entries are {sample_tick, debounced_signal[1:0]} after a posedge.
  logic [2:0] exp_q[$];

  debouncer #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .SAMPLE_CNT_MAX (SMAX),
    .PULSE_CNT_MAX  (PMAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .signal_in        (signal_in),
    .debounced_signal (debounced_signal),
    .sample_tick      (sample_tick)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst       = 1'b1;
    signal_in = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- reference model ----------------
  int         m_timer;
  int         m_cnt [2];
  logic [1:0] m_s0, m_s1;
  logic       m_tk;
  int         m_nc [2];
  int         m_nt;

  always_comb begin
    m_nc[0] = 0;
    m_nc[1] = 0;
    m_tk    = (m_timer == SMAX - 1);
    for (int b = 0; b < 2; b++) begin
      if (m_s1[b] == 1'b0) m_nc[b] = 0;
      else if (m_tk && (m_cnt[b] < PMAX)) m_nc[b] = m_cnt[b] + 1;
      else m_nc[b] = m_cnt[b];
    end
    m_nt = m_tk ? 0 : m_timer + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_timer  <= 0;
      m_cnt[0] <= 0;
      m_cnt[1] <= 0;
      m_s0     <= 2'b00;
      m_s1     <= 2'b00;
    end else begin
      m_timer  <= m_nt;
      m_cnt[0] <= m_nc[0];
      m_cnt[1] <= m_nc[1];
      m_s0     <= signal_in;
      m_s1     <= m_s0;
      exp_q.push_back({(m_nt == SMAX - 1), (m_nc[1] == PMAX), (m_nc[0] == PMAX)});
    end
  end

  // Downstream edge detector stand-in for the chain check.
  logic prev0;
  logic edge_pulse0;
  always @(posedge clk or posedge rst) begin
    if (rst) prev0 <= 1'b0;
    else     prev0 <= debounced_signal[0];
  end
  assign edge_pulse0 = debounced_signal[0] & ~prev0;

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_tick;
    int   waited;
    #2;
    n_cmp++;
    if ({sample_tick, debounced_signal} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_hold: got %b expected 000", {sample_tick, debounced_signal});
    end
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_tick = ((k % SMAX) == SMAX - 1);
      n_cmp++;
      if (sample_tick !== exp_tick) begin
        n_err++;
        $display("FAIL tick_phase k=%0d: got %b expected %b", k, sample_tick, exp_tick);
      end
    end
    // Qualify bit0, then reset in the middle of a cycle.
    signal_in = 2'b01;
    waited = 0;
    while (debounced_signal[0] !== 1'b1 && waited < TIMEOUT) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    if (debounced_signal[0] !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prequal: got %b expected 1", debounced_signal[0]);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({sample_tick, debounced_signal} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_async: got %b expected 000", {sample_tick, debounced_signal});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    // bit0 still high: qualification restarts from zero with timer phase 0.
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_tick = ((k % SMAX) == SMAX - 1);
      n_cmp++;
      if ({sample_tick, debounced_signal} !== {exp_tick, 1'b0, (k >= 12)}) begin
        n_err++;
        $display("FAIL reset_restart k=%0d: got %b expected %b", k,
                 {sample_tick, debounced_signal}, {exp_tick, 1'b0, (k >= 12)});
      end
    end
    signal_in = 2'b00;
  endtask

  task automatic test_steady_press();
    logic [2:0] exp;
    int rise_at;
    int drops;
    apply_reset();
    signal_in = 2'b01;
    rise_at = -1;
    drops   = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL steady_sb c=%0d: queue empty, got %b", c, {sample_tick, debounced_signal});
      end else begin
        exp = exp_q.pop_front();
        if ({sample_tick, debounced_signal} !== exp) begin
          n_err++;
          $display("FAIL steady_sb c=%0d: got %b expected %b", c, {sample_tick, debounced_signal}, exp);
        end
      end
      if (debounced_signal[0] === 1'b1 && rise_at < 0) rise_at = c;
      if (rise_at >= 0 && debounced_signal[0] !== 1'b1) drops++;
      n_cmp++;
      if (debounced_signal[1] !== 1'b0) begin
        n_err++;
        $display("FAIL steady_bit1 c=%0d: got %b expected 0", c, debounced_signal[1]);
      end
    end
    // sync rises after posedge 2; rise must land 9..12 cycles later.
    n_cmp++;
    if (rise_at < 2 + (PMAX - 1) * SMAX + 1 || rise_at > 2 + PMAX * SMAX) begin
      n_err++;
      $display("FAIL steady_latency: got cycle %0d expected 11..14", rise_at);
    end
    n_cmp++;
    if (drops != 0) begin
      n_err++;
      $display("FAIL steady_hold: got %0d low cycles expected 0", drops);
    end
    signal_in = 2'b00;
  endtask

  task automatic test_bounce();
    logic [2:0] exp;
    int highs;
    apply_reset();
    highs = 0;
    for (int c = 0; c < 60; c++) begin
      signal_in[0] = ((c / 3) % 2 == 0);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL bounce_sb c=%0d: queue empty, got %b", c, {sample_tick, debounced_signal});
      end else begin
        exp = exp_q.pop_front();
        if ({sample_tick, debounced_signal} !== exp) begin
          n_err++;
          $display("FAIL bounce_sb c=%0d: got %b expected %b", c, {sample_tick, debounced_signal}, exp);
        end
      end
      if (debounced_signal[0] !== 1'b0) highs++;
    end
    n_cmp++;
    if (highs != 0) begin
      n_err++;
      $display("FAIL bounce_reject: got %0d high cycles expected 0", highs);
    end
    signal_in = 2'b00;
  endtask

  task automatic test_release();
    int waited;
    apply_reset();
    signal_in = 2'b01;
    waited = 0;
    while (debounced_signal[0] !== 1'b1 && waited < TIMEOUT) begin
      @(posedge clk); #1;
      waited++;
    end
    n_cmp++;
    if (debounced_signal[0] !== 1'b1) begin
      n_err++;
      $display("FAIL release_qual: timeout, got %b expected 1", debounced_signal[0]);
    end
    @(posedge clk); #1;
    signal_in = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (debounced_signal[0] !== (k < 3)) begin
        n_err++;
        $display("FAIL release_latency k=%0d: got %b expected %b", k, debounced_signal[0], (k < 3));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp;
    apply_reset();
    signal_in = 2'b11;
    // Ticks occupy the cycles after posedges 3, 7, 11, ... A one-cycle low on
    // bit1 lands in sync during the tick cycle after posedge 11.
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if (k == 9)  signal_in[1] = 1'b0;
      if (k == 10) signal_in[1] = 1'b1;
      exp = {(k >= 24), (k >= 12)};
      n_cmp++;
      if (debounced_signal !== exp) begin
        n_err++;
        $display("FAIL simul k=%0d: got %b expected %b", k, debounced_signal, exp);
      end
    end
    signal_in = 2'b00;
  endtask

  task automatic test_chain();
    int pulses;
    apply_reset();
    pulses = 0;
    signal_in = 2'b01;
    for (int c = 0; c < 60; c++) begin
      if (c == 40) signal_in = 2'b00;
      @(negedge clk);
      if (edge_pulse0 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL chain_press: got %0d pulses expected 1", pulses);
    end
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      signal_in[0] = (c < 60) && ((c / 2) % 2 == 0);
      @(negedge clk);
      if (edge_pulse0 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL chain_bounce: got %0d pulses expected 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_steady_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
